// File: rtl/tx_frame_builder_pkg.sv
// Shared constants and state encoding for the Ethernet TX frame builder
// and the matching RX-side CRC checker.
package tx_frame_builder_pkg;

   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
   // CRC register value after a good frame including its FCS (no final xor)
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

   localparam int ETH_MIN_FRAME = 60;
   localparam int ETH_MAX_FRAME = 1514;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_DATA = 3'd1,
      S_PAD  = 3'd2,
      S_FCS  = 3'd3,
      S_DROP = 3'd4
   } state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational Ethernet CRC-32 update for one byte, reflected polynomial,
// bits consumed LSB first.
module crc32_d8
   import tx_frame_builder_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  d,
   output logic [31:0] crc_out
);

   logic [31:0] w_c;

   // Shift the eight data bits through the LFSR, LSB first
   always_comb begin
      w_c = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (w_c[0] ^ d[i]) begin
            w_c = (w_c >> 1) ^ CRC32_POLY_REFL;
         end else begin
            w_c = w_c >> 1;
         end
      end
      crc_out = w_c;
   end

endmodule

// File: rtl/my_bin2gray.sv
// Binary to reflected-gray conversion for counters crossing clock domains.
module my_bin2gray #(
   parameter int WIDTH = 16
)(
   input  logic [WIDTH-1:0] i_bin,
   output logic [WIDTH-1:0] o_gray
);

   // Each gray bit is the xor of neighbouring binary bits
   always_comb begin
      o_gray = i_bin ^ (i_bin >> 1);
   end

endmodule

// File: rtl/tx_frame_builder.sv
// Frame builder in front of the RMII transmitter: pads short frames with
// zeros, appends the CRC-32 FCS and marks the last FCS byte with EOD.
// Overlong frames are cut at MAX_FRAME, get a deliberately bad FCS and the
// rest of the input frame is swallowed.
module tx_frame_builder
   import tx_frame_builder_pkg::*;
#(
   parameter int MIN_FRAME = ETH_MIN_FRAME,
   parameter int MAX_FRAME = ETH_MAX_FRAME,
   parameter int BCNT_W    = 11
)(
   input  logic        REF_CLK,
   input  logic        arst_n,
   input  logic [7:0]  in_tdata,
   input  logic        in_tvalid,
   input  logic        in_tlast,
   output logic        in_tready,
   output logic [7:0]  fifo_din,
   output logic        fifo_EOD_in,
   output logic        fifo_wren,
   input  logic        fifo_full,
   output logic [15:0] frame_count_gray,
   output logic [15:0] oversize_count_gray
);

   localparam logic [BCNT_W-1:0] MIN_B   = BCNT_W'(MIN_FRAME);
   localparam logic [BCNT_W-1:0] MAX_B   = BCNT_W'(MAX_FRAME);
   localparam bit                MIN_LE1 = (MIN_FRAME <= 1);

   state_t            r_state, w_state_nxt;
   logic [BCNT_W-1:0] r_bcnt, w_bcnt_nxt, w_bcnt_inc;
   logic [31:0]       r_crc, w_crc_nxt, w_crc_upd, w_fcs;
   logic [15:0]       r_frame_cnt, w_frame_cnt_nxt;
   logic [15:0]       r_over_cnt, w_over_cnt_nxt;
   logic              r_oversize, w_oversize_nxt;
   logic [1:0]        r_fcs_idx, w_fcs_idx_nxt;
   logic              r_ready_en;
   logic [7:0]        w_crc_d, w_fcs_byte;
   logic              w_accept;

   assign w_bcnt_inc = r_bcnt + {{(BCNT_W-1){1'b0}}, 1'b1};
   assign w_accept   = in_tvalid & in_tready;
   // Oversize frames get the FCS inverted a second time so the receiver drops them
   assign w_fcs      = ~r_crc ^ {32{r_oversize}};

   crc32_d8 u_crc (
      .crc_in  (r_crc),
      .d       (w_crc_d),
      .crc_out (w_crc_upd)
   );

   my_bin2gray #(.WIDTH(16)) u_gray_frames (
      .i_bin  (r_frame_cnt),
      .o_gray (frame_count_gray)
   );

   my_bin2gray #(.WIDTH(16)) u_gray_oversize (
      .i_bin  (r_over_cnt),
      .o_gray (oversize_count_gray)
   );

   // Select the CRC input byte and the FCS byte currently on offer
   always_comb begin
      w_crc_d = (r_state == S_PAD) ? 8'h00 : in_tdata;
      case (r_fcs_idx)
         2'd0:    w_fcs_byte = w_fcs[7:0];
         2'd1:    w_fcs_byte = w_fcs[15:8];
         2'd2:    w_fcs_byte = w_fcs[23:16];
         2'd3:    w_fcs_byte = w_fcs[31:24];
         default: w_fcs_byte = 8'h00;
      endcase
   end

   // Next-state, handshake and FIFO write decode; full FIFO freezes every state
   always_comb begin
      w_state_nxt     = r_state;
      w_bcnt_nxt      = r_bcnt;
      w_crc_nxt       = r_crc;
      w_frame_cnt_nxt = r_frame_cnt;
      w_over_cnt_nxt  = r_over_cnt;
      w_oversize_nxt  = r_oversize;
      w_fcs_idx_nxt   = r_fcs_idx;
      in_tready       = 1'b0;
      fifo_wren       = 1'b0;
      fifo_din        = 8'h00;
      fifo_EOD_in     = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_tready = r_ready_en & ~fifo_full;
            fifo_din  = in_tdata;
            fifo_wren = w_accept;
            if (w_accept) begin
               w_bcnt_nxt = {{(BCNT_W-1){1'b0}}, 1'b1};
               w_crc_nxt  = w_crc_upd;
               if (in_tlast) begin
                  w_state_nxt = MIN_LE1 ? S_FCS : S_PAD;
               end else begin
                  w_state_nxt = S_DATA;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_DATA: begin
            in_tready = r_ready_en & ~fifo_full;
            fifo_din  = in_tdata;
            fifo_wren = w_accept;
            if (w_accept) begin
               w_bcnt_nxt = w_bcnt_inc;
               w_crc_nxt  = w_crc_upd;
               if (in_tlast) begin
                  w_state_nxt = (w_bcnt_inc < MIN_B) ? S_PAD : S_FCS;
               end else if (w_bcnt_inc == MAX_B) begin
                  w_oversize_nxt = 1'b1;
                  w_state_nxt    = S_FCS;
               end else begin
                  w_state_nxt = S_DATA;
               end
            end else begin
               w_state_nxt = S_DATA;
            end
         end
         S_PAD: begin
            fifo_wren = r_ready_en & ~fifo_full;
            fifo_din  = 8'h00;
            if (fifo_wren) begin
               w_bcnt_nxt  = w_bcnt_inc;
               w_crc_nxt   = w_crc_upd;
               w_state_nxt = (w_bcnt_inc == MIN_B) ? S_FCS : S_PAD;
            end else begin
               w_state_nxt = S_PAD;
            end
         end
         S_FCS: begin
            fifo_wren   = r_ready_en & ~fifo_full;
            fifo_din    = w_fcs_byte;
            fifo_EOD_in = fifo_wren & (r_fcs_idx == 2'd3);
            if (fifo_wren) begin
               w_fcs_idx_nxt = r_fcs_idx + 2'd1;
               if (r_fcs_idx == 2'd3) begin
                  w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                  w_over_cnt_nxt  = r_over_cnt + {15'd0, r_oversize};
                  w_bcnt_nxt      = {BCNT_W{1'b0}};
                  w_crc_nxt       = CRC32_INIT;
                  w_oversize_nxt  = 1'b0;
                  w_state_nxt     = r_oversize ? S_DROP : S_IDLE;
               end else begin
                  w_state_nxt = S_FCS;
               end
            end else begin
               w_state_nxt = S_FCS;
            end
         end
         S_DROP: begin
            in_tready = r_ready_en;
            if (w_accept && in_tlast) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DROP;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, CRC and counter registers; ready_en holds off the handshake one edge after reset
   always_ff @(posedge REF_CLK or negedge arst_n) begin
      if (!arst_n) begin
         r_state     <= S_IDLE;
         r_bcnt      <= {BCNT_W{1'b0}};
         r_crc       <= CRC32_INIT;
         r_frame_cnt <= 16'd0;
         r_over_cnt  <= 16'd0;
         r_oversize  <= 1'b0;
         r_fcs_idx   <= 2'd0;
         r_ready_en  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bcnt      <= w_bcnt_nxt;
         r_crc       <= w_crc_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
         r_over_cnt  <= w_over_cnt_nxt;
         r_oversize  <= w_oversize_nxt;
         r_fcs_idx   <= w_fcs_idx_nxt;
         r_ready_en  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tx_frame_builder.sv
// Directed bench for tx_frame_builder: one instance with MIN_FRAME=9 for the
// classic "123456789" check vector, one with default parameters for padding,
// stalls, oversize, back-to-back and mid-frame reset.
module tb_tx_frame_builder;
   import tx_frame_builder_pkg::*;

   logic        clk = 1'b0;
   logic        arst_n;
   logic [7:0]  tdata  [2];
   logic        tvalid [2];
   logic        tlast  [2];
   logic        full   [2];
   logic        tready [2];
   logic        wren   [2];
   logic        eod    [2];
   logic [7:0]  din    [2];
   logic [15:0] fcg    [2];
   logic [15:0] ocg    [2];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int stall_viol = 0;
   int stall_cyc = 0;
   logic [8:0] wq0[$], wq1[$], exp_q[$], ref_q[$];
   logic [7:0] data_q[$];
   int ts1[$];

   always #10 clk = ~clk;

   tx_frame_builder #(.MIN_FRAME(9)) u_dut_min9 (
      .REF_CLK(clk), .arst_n(arst_n),
      .in_tdata(tdata[0]), .in_tvalid(tvalid[0]), .in_tlast(tlast[0]), .in_tready(tready[0]),
      .fifo_din(din[0]), .fifo_EOD_in(eod[0]), .fifo_wren(wren[0]), .fifo_full(full[0]),
      .frame_count_gray(fcg[0]), .oversize_count_gray(ocg[0])
   );

   tx_frame_builder u_dut (
      .REF_CLK(clk), .arst_n(arst_n),
      .in_tdata(tdata[1]), .in_tvalid(tvalid[1]), .in_tlast(tlast[1]), .in_tready(tready[1]),
      .fifo_din(din[1]), .fifo_EOD_in(eod[1]), .fifo_wren(wren[1]), .fifo_full(full[1]),
      .frame_count_gray(fcg[1]), .oversize_count_gray(ocg[1])
   );

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO-side monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (wren[0] && !full[0]) wq0.push_back({eod[0], din[0]});
      if (wren[1] && !full[1]) begin
         wq1.push_back({eod[1], din[1]});
         ts1.push_back(cyc);
      end
      if (full[1]) begin
         stall_cyc++;
         if (tready[1] || wren[1]) stall_viol++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [31:0] residue1();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (wq1[i]) c = crc_byte(c, wq1[i][7:0]);
      return c;
   endfunction

   task automatic send(input int s, input logic [7:0] b, input logic last);
      bit got;
      got = 1'b0;
      tdata[s] = b; tlast[s] = last; tvalid[s] = 1'b1;
      for (int g = 0; g < 4000 && !got; g++) begin
         @(negedge clk);
         got = tready[s];
         @(posedge clk); #1;
      end
      if (!got) chk("send_timeout", 32'(got), 32'd1);
   endtask

   task automatic send_frame(input int s, input int n, input int seed, input bit hold);
      logic [7:0] b;
      data_q.delete();
      for (int i = 0; i < n; i++) begin
         b = 8'(i * 7 + seed);
         data_q.push_back(b);
         send(s, b, i == n - 1);
      end
      if (!hold) tvalid[s] = 1'b0;
   endtask

   task automatic build_exp(input int n_keep, input int pad_to, input bit ovs);
      logic [31:0] c, f;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n_keep; i++) begin
         exp_q.push_back({1'b0, data_q[i]});
         c = crc_byte(c, data_q[i]);
      end
      for (int i = n_keep; i < pad_to; i++) begin
         exp_q.push_back(9'h000);
         c = crc_byte(c, 8'h00);
      end
      f = ~c ^ {32{ovs}};
      exp_q.push_back({1'b0, f[7:0]});
      exp_q.push_back({1'b0, f[15:8]});
      exp_q.push_back({1'b0, f[23:16]});
      exp_q.push_back({1'b1, f[31:24]});
   endtask

   task automatic cmp_exp(input string tag, input int s);
      int n, d;
      logic [8:0] v;
      d = 0;
      n = (s == 0) ? wq0.size() : wq1.size();
      chk({tag, "_len"}, 32'(n), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < n) v = (s == 0) ? wq0[i] : wq1[i];
         else v = 9'bx;
         if (v !== exp_q[i]) d++;
      end
      chk({tag, "_bytes"}, 32'(d), 32'd0);
   endtask

   task automatic cmp_ref(input string tag);
      int d;
      d = 0;
      chk({tag, "_len"}, 32'(wq1.size()), 32'(ref_q.size()));
      for (int i = 0; i < ref_q.size(); i++) begin
         if (i >= wq1.size()) d++;
         else if (wq1[i] !== ref_q[i]) d++;
      end
      chk({tag, "_bytes"}, 32'(d), 32'd0);
   endtask

   task automatic wait_writes(input int s, input int n);
      for (int g = 0; g < 20000 && ((s == 0) ? wq0.size() : wq1.size()) < n; g++) @(posedge clk);
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic stall_at(input int n);
      for (int g = 0; g < 20000 && wq1.size() < n; g++) @(posedge clk);
      #1 full[1] = 1'b1;
      repeat (5) @(posedge clk);
      #1 full[1] = 1'b0;
   endtask

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap, span;
      logic [31:0] fcs_w;
      arst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         tvalid[s] = 1'b0; tlast[s] = 1'b0; tdata[s] = 8'h00; full[s] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tready", 32'(tready[1]), 32'd0);
      chk("rst_wren", 32'(wren[1]), 32'd0);
      chk("rst_fcg", 32'(fcg[1]), 32'd0);
      chk("rst_ocg", 32'(ocg[1]), 32'd0);
      @(posedge clk); #1 arst_n = 1'b1;
      @(negedge clk); chk("rel_ready_low", 32'(tready[1]), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); chk("rel_ready_high", 32'(tready[1]), 32'd1);
      @(posedge clk); #1;

      // "123456789" on the MIN_FRAME=9 instance: no pad, FCS 0xCBF43926
      for (int i = 0; i < 9; i++) send(0, 8'h31 + 8'(i), i == 8);
      tvalid[0] = 1'b0;
      wait_writes(0, 13);
      exp_q = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h036, 9'h037, 9'h038, 9'h039,
                9'h026, 9'h039, 9'h0F4, 9'h1CB};
      cmp_exp("t1", 0);
      fcs_w = (wq0.size() >= 13) ? {wq0[12][7:0], wq0[11][7:0], wq0[10][7:0], wq0[9][7:0]} : 32'h0;
      chk("t1_fcs", fcs_w, 32'hCBF43926);
      chk("t1_fcg", 32'(fcg[0]), 32'h0001);

      // 14-byte frame, default parameters: 46 pad bytes
      wq1.delete();
      send_frame(1, 14, 3, 1'b0);
      wait_writes(1, 64);
      exp_q.delete();
      build_exp(14, 60, 1'b0);
      cmp_exp("t2", 1);
      chk("t2_residue", residue1(), 32'hDEBB20E3);
      chk("t2_fcg", 32'(fcg[1]), 32'h0001);
      ref_q = wq1;

      // Same frame with FIFO-full stalls in data, pad and on the 3rd FCS byte
      wq1.delete();
      stall_cyc = 0;
      stall_viol = 0;
      fork
         send_frame(1, 14, 3, 1'b0);
         begin
            stall_at(5);
            stall_at(20);
            stall_at(62);
         end
      join
      wait_writes(1, 64);
      cmp_ref("t3");
      chk("t3_stall_cycles", 32'(stall_cyc), 32'd15);
      chk("t3_low_while_full", 32'(stall_viol), 32'd0);
      chk("t3_fcg", 32'(fcg[1]), 32'h0003);

      // 1600-byte input: truncated to 1514, inverted FCS, 86 bytes discarded
      wq1.delete();
      send_frame(1, 1600, 11, 1'b0);
      wait_writes(1, 1518);
      exp_q.delete();
      build_exp(1514, 1514, 1'b1);
      cmp_exp("t4", 1);
      chk("t4_residue_bad", 32'(residue1() != 32'hDEBB20E3), 32'd1);
      chk("t4_ocg", 32'(ocg[1]), 32'h0001);
      chk("t4_fcg", 32'(fcg[1]), 32'h0002);

      // Back-to-back 60-byte frames, tvalid held high throughout
      wq1.delete();
      ts1.delete();
      send_frame(1, 60, 21, 1'b1);
      send_frame(1, 60, 21, 1'b0);
      wait_writes(1, 128);
      exp_q.delete();
      build_exp(60, 60, 1'b0);
      build_exp(60, 60, 1'b0);
      cmp_exp("t5", 1);
      gap  = (ts1.size() >= 128) ? ts1[64] - ts1[63] : -1;
      span = (ts1.size() >= 128) ? ts1[127] - ts1[0] : -1;
      chk("t5_b2b_gap", 32'(gap), 32'd1);
      chk("t5_span", 32'(span), 32'd127);
      chk("t5_fcg", 32'(fcg[1]), 32'h0007);
      chk("t5_ocg", 32'(ocg[1]), 32'h0001);

      // Reset in the middle of a frame, then a clean frame
      for (int i = 0; i < 20; i++) send(1, 8'hA0 + 8'(i), 1'b0);
      tvalid[1] = 1'b0;
      arst_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_fcg", 32'(fcg[1]), 32'd0);
      chk("t6_rst_ocg", 32'(ocg[1]), 32'd0);
      @(posedge clk); #1 arst_n = 1'b1;
      @(negedge clk); chk("t6_ready_low", 32'(tready[1]), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); chk("t6_ready_high", 32'(tready[1]), 32'd1);
      @(posedge clk); #1;
      wq1.delete();
      send_frame(1, 14, 3, 1'b0);
      wait_writes(1, 64);
      cmp_ref("t6");
      chk("t6_fcg", 32'(fcg[1]), 32'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
